// File: rtl/instr_mem_loader.sv
// Boot loader front end: assembles a little-endian byte stream into words,
// writes them to instruction memory and holds the CPU in reset until done.
module instr_mem_loader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         widx_q, widx_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  hs;

  // byte_ready is high exactly in RECV, so it doubles as the accept qualifier
  assign hs = byte_valid & byte_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    asm_d   = asm_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          if ((load_len != '0) && (load_len <= LW'(MEM_DEPTH))) begin
            state_d = S_RECV;
            len_d   = load_len;
            widx_d  = '0;
            bcnt_d  = '0;
            tcnt_d  = '0;
            asm_d   = '0;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_RECV: begin
        if (hs) begin
          asm_d[8*int'(bcnt_q) +: 8] = byte_in;
          tcnt_d = '0;
          if (bcnt_q == BCW'(BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WRITE: begin
        widx_d  = widx_q + LW'(1);
        bcnt_d  = '0;
        tcnt_d  = '0;
        state_d = ((widx_q + LW'(1)) == len_q) ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      widx_q <= '0;
      bcnt_q <= '0;
      tcnt_q <= '0;
      asm_q  <= '0;
    end else begin
      len_q  <= len_d;
      widx_q <= widx_d;
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
      asm_q  <= asm_d;
    end
  end

  // Registered outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_ready       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      cpu_reset        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      byte_ready       <= (state_d == S_RECV);
      mem_write_enable <= (state_d == S_WRITE);
      cpu_reset        <= (state_d != S_DONE);
      busy             <= (state_d == S_RECV) || (state_d == S_WRITE);
      done             <= (state_d == S_DONE);
      error            <= (state_d == S_ERROR);
      if (state_d == S_WRITE) begin
        mem_address    <= widx_q[ADDR_WIDTH-1:0];
        mem_write_data <= asm_d;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: length table, directed loads,
// timeout, async reset, full-depth load and randomized loads vs a word model.
module tb_instr_mem_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned TO = 1024;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  instr_mem_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .cpu_reset(cpu_reset), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    tx_q[$];
  logic [DW-1:0] exp_q[$];
  int            wr_cyc[$];
  int            wr_cnt, hs_cnt, done_cyc, err_cyc, last_hs;
  logic [AW-1:0] last_addr;
  logic          cpu_rst_done;

  typedef struct {
    logic [AW:0] len;
    logic        exp_err;
    logic        exp_busy;
  } len_vec_t;

  len_vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
    check({tag, "_wen"}, 64'(mem_write_enable), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_addr"}, 64'(mem_address), 64'(0));
    check({tag, "_data"}, 64'(mem_write_data), 64'(0));
  endtask

  // Expected words: consecutive groups of NB bytes, first byte least significant
  task automatic build_words();
    logic [DW-1:0] w;
    exp_q.delete();
    for (int i = 0; i < tx_q.size() / NB; i++) begin
      w = '0;
      for (int b = 0; b < NB; b++) w = w | (DW'(tx_q[i*NB + b]) << (8 * b));
      exp_q.push_back(w);
    end
  endtask

  task automatic random_tx(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  // gap>0: idle cycles after each accepted byte; gap<0: random valid
  task automatic run_load(input int len, input int gap, input bit nogap_write, input int maxcyc);
    int  gap_left;
    int  idx;
    bit  hs;
    gap_left = 0;
    idx = 0;
    wr_cnt = 0; hs_cnt = 0; done_cyc = -1; err_cyc = -1; last_hs = -1;
    wr_cyc.delete();
    load_len = (AW+1)'(len);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int c = 0; c < maxcyc; c++) begin
      if (gap_left == 0 && idx < tx_q.size() && (gap >= 0 || $urandom_range(1, 0) == 1)) begin
        byte_valid = 1'b1;
        byte_in = tx_q[idx];
      end else begin
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
      end
      hs = byte_valid && byte_ready;
      if (done && error) check("done_error_exclusive", 64'(1), 64'(0));
      if (mem_write_enable) begin
        check("wr_addr", 64'(mem_address), 64'(wr_cnt));
        if (wr_cnt < exp_q.size()) check("wr_data", 64'(mem_write_data), 64'(exp_q[wr_cnt]));
        else check("unexpected_write", 64'(1), 64'(0));
        if (byte_valid) check("ready_low_in_write", 64'(byte_ready), 64'(0));
        wr_cnt++;
        wr_cyc.push_back(c);
        last_addr = mem_address;
      end
      if (done) begin
        done_cyc = c;
        cpu_rst_done = cpu_reset;
        break;
      end
      if (error) begin
        err_cyc = c;
        break;
      end
      step();
      if (hs) begin
        idx++;
        hs_cnt++;
        last_hs = c;
        gap_left = (nogap_write && (idx % NB) == 0) ? 0 : ((gap > 0) ? gap : 0);
      end else if (gap_left > 0) begin
        gap_left--;
      end
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    int len;
    int strobes;
    int min_gap;
    reset = 1'b0;
    load_start = 1'b0;
    load_len = '0;
    byte_in = '0;
    byte_valid = 1'b0;

    vecs[0] = '{len: 9'd0,   exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{len: 9'd257, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{len: 9'd511, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{len: 9'd256, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[4] = '{len: 9'd1,   exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{len: 9'd37,  exp_err: 1'b0, exp_busy: 1'b1};

    step();
    step();
    check_reset_vals("por");
    reset = 1'b1;

    // Length acceptance table, each from a fresh reset
    foreach (vecs[i]) begin
      apply_reset();
      load_len = vecs[i].len;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check($sformatf("len%0d_error", vecs[i].len), 64'(error), 64'(vecs[i].exp_err));
      check($sformatf("len%0d_busy", vecs[i].len), 64'(busy), 64'(vecs[i].exp_busy));
      check($sformatf("len%0d_ready", vecs[i].len), 64'(byte_ready), 64'(vecs[i].exp_busy));
      check($sformatf("len%0d_cpu_reset", vecs[i].len), 64'(cpu_reset), 64'(1));
    end
    apply_reset();

    // Continuous two-word load with exact latency
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    build_words();
    run_load(2, 0, 1'b0, 200);
    check("cont_writes", 64'(wr_cnt), 64'(2));
    check("cont_strobe0_cyc", 64'((wr_cyc.size() > 0) ? wr_cyc[0] : -1), 64'(NB));
    check("cont_strobe1_cyc", 64'((wr_cyc.size() > 1) ? wr_cyc[1] : -1), 64'(2*NB + 1));
    check("cont_done_cyc", 64'(done_cyc), 64'(2*NB + 2));
    check("cont_cpu_reset", 64'(cpu_rst_done), 64'(0));
    check("cont_bytes", 64'(hs_cnt), 64'(8));

    // Same load with gaps, and a byte offered during each WRITE cycle
    run_load(2, 5, 1'b1, 400);
    check("gap_done", 64'(done_cyc >= 0), 64'(1));
    check("gap_writes", 64'(wr_cnt), 64'(2));
    check("gap_bytes", 64'(hs_cnt), 64'(8));
    check("gap_cpu_reset", 64'(cpu_rst_done), 64'(0));

    // Timeout after a partial word, then a fresh load recovers
    random_tx(3);
    build_words();
    run_load(1, 0, 1'b0, TO + 100);
    check("to_error_seen", 64'(err_cyc >= 0), 64'(1));
    check("to_latency", 64'(err_cyc - last_hs), 64'(TO + 1));
    check("to_writes", 64'(wr_cnt), 64'(0));
    check("to_cpu_reset", 64'(cpu_reset), 64'(1));
    check("to_done", 64'(done), 64'(0));
    check("to_ready", 64'(byte_ready), 64'(0));
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    build_words();
    run_load(1, 0, 1'b0, 100);
    check("rec_done", 64'(done_cyc >= 0), 64'(1));
    check("rec_writes", 64'(wr_cnt), 64'(1));
    check("rec_word", 64'(exp_q[0]), 64'(32'h1));

    // Zero length from DONE
    load_len = '0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("zero_error", 64'(error), 64'(1));
    check("zero_done", 64'(done), 64'(0));
    check("zero_ready", 64'(byte_ready), 64'(0));

    // Async reset after five bytes of a two-word load
    apply_reset();
    random_tx(5);
    build_words();
    run_load(2, 0, 1'b0, 12);
    check("ar_writes_before", 64'(wr_cnt), 64'(1));
    check("ar_busy_before", 64'(busy), 64'(1));
    #3 reset = 1'b0;
    #1 check_reset_vals("async");
    step();
    reset = 1'b1;
    strobes = 0;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_write_enable) strobes++;
      step();
    end
    byte_valid = 1'b0;
    check("ar_no_word1", 64'(strobes), 64'(0));

    // Full-depth load, no address wrap
    random_tx(DEPTH * NB);
    build_words();
    run_load(DEPTH, 0, 1'b0, DEPTH * (NB + 1) + 50);
    check("full_done", 64'(done_cyc >= 0), 64'(1));
    check("full_writes", 64'(wr_cnt), 64'(DEPTH));
    check("full_last_addr", 64'(last_addr), 64'(DEPTH - 1));
    check("full_cpu_reset", 64'(cpu_rst_done), 64'(0));

    // Randomized loads with random byte_valid
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(6, 1);
      random_tx(len * NB);
      build_words();
      run_load(len, -1, 1'b0, 800);
      check($sformatf("rnd%0d_done", it), 64'(done_cyc >= 0), 64'(1));
      check($sformatf("rnd%0d_writes", it), 64'(wr_cnt), 64'(len));
      check($sformatf("rnd%0d_bytes", it), 64'(hs_cnt), 64'(len * NB));
      check($sformatf("rnd%0d_done_lat", it),
            64'(done_cyc - ((wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -10)), 64'(1));
      min_gap = 1000;
      for (int k = 1; k < wr_cyc.size(); k++)
        if (wr_cyc[k] - wr_cyc[k-1] < min_gap) min_gap = wr_cyc[k] - wr_cyc[k-1];
      if (wr_cyc.size() > 1)
        check($sformatf("rnd%0d_spacing", it), 64'(min_gap >= NB + 1), 64'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer-side front end for the instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian words. Each word is written to a synchronous instruction-memory write port at consecutive word addresses. The CPU is held in reset until the load completes, so the block sits between the external boot link and the Instruction_Memory write port and CPU_Top reset.

Parameters:
DATA_WIDTH, 32, instruction word width; must be a multiple of 8 (BYTES = DATA_WIDTH/8)
ADDR_WIDTH, 8, instruction memory word-address width
MEM_DEPTH, 256, number of words in instruction memory; must be <= 2**ADDR_WIDTH
TIMEOUT_CYCLES, 1024, consecutive RECV cycles without a byte handshake before ERROR

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
load_start  input  1  one-cycle request to begin a load; sampled in IDLE, DONE and ERROR only
load_len  input  ADDR_WIDTH+1  number of words to load; sampled with load_start
byte_in  input  8  program byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_write_enable  output  1  one-cycle write strobe to instruction memory
mem_address  output  ADDR_WIDTH  word address for the write
mem_write_data  output  DATA_WIDTH  assembled word
cpu_reset  output  1  active-high reset to CPU_Top
busy  output  1  load in progress (RECV or WRITE)
done  output  1  load completed successfully
error  output  1  load aborted (bad length or timeout)

Behaviour:
- Reset (reset=0, asynchronous) forces these values immediately:
  - state=IDLE, cpu_reset=1.
  - byte_ready, mem_write_enable, busy, done, error all 0.
  - mem_address=0, mem_write_data=0.
  - Internal byte/word/timeout counters cleared; any partial word is discarded.
- All outputs are registered.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE, DONE or ERROR, when load_start=1:
  - 1 <= load_len <= MEM_DEPTH: latch len, clear word index, byte count, timeout count and the assembly register; go to RECV next cycle.
  - Otherwise: go to ERROR.
  - cpu_reset=1 from the cycle after load_start until DONE.
  - load_start is ignored in RECV and WRITE.
- RECV:
  - byte_ready=1, busy=1.
  - A handshake (byte_valid & byte_ready) places byte_in at bits [8k+7:8k], where k is the byte count (first byte is the LSB), then increments k.
  - The handshake that delivers byte BYTES-1 moves the FSM to WRITE.
  - byte_valid while byte_ready=0 is not consumed; the source holds the byte.
- WRITE (exactly one cycle):
  - mem_write_enable=1, mem_address = word index, mem_write_data = assembled word; byte_ready=0, busy=1.
  - Next cycle: word index+1, k=0.
  - If words written == len, go to DONE; else go to RECV.
- Latency: last byte handshake at cycle N -> write strobe at N+1 -> (last word) done=1 and cpu_reset=0 at N+2.
- Peak throughput: one word per BYTES+1 cycles.
- mem_address never wraps. The maximum is MEM_DEPTH-1, reached only when len=MEM_DEPTH.
- Timeout:
  - In RECV the counter clears on every handshake and on RECV entry, and increments on every RECV cycle without a handshake.
  - After TIMEOUT_CYCLES consecutive non-handshake cycles, the FSM goes to ERROR; the partial word is never written.
- DONE: done=1, cpu_reset=0, busy=0, byte_ready=0. Held until load_start or reset.
- ERROR: error=1, cpu_reset=1, busy=0, byte_ready=0. Held until load_start (restart) or reset.
- done and error are never 1 together. Both clear the cycle after an accepted load_start.
- Reset mid-load: outputs return to reset values immediately; memory words already written are not undone.

Test Plan:
- Assert reset=0 for 2 cycles -> cpu_reset=1, all other outputs 0; mem_address=0.
- load_len=2, then continuous bytes 78 56 34 12 EF BE AD DE ->
  - writes addr 0x00=0x12345678 and addr 0x01=0xDEADBEEF, each a single-cycle mem_write_enable;
  - done=1 and cpu_reset=0 exactly 1 cycle after the second strobe.
- Same load with 5-cycle gaps in byte_valid and a byte presented during the WRITE cycle -> identical memory contents; the byte presented in WRITE is accepted only once, in the following RECV cycle.
- load_len=1, 3 bytes, then byte_valid=0 for TIMEOUT_CYCLES ->
  - error=1, no write strobe, cpu_reset=1;
  - a new load_start with 4 bytes 01 00 00 00 -> addr 0x00=0x00000001, done=1.
- load_len=0, then load_len=257 -> error=1 the cycle after load_start, no byte_ready.
- Drive reset=0 asynchronously after 5 bytes of a 2-word load -> immediate reset values, word 1 never written. Separately, load 256 words -> last strobe at address 0xFF, no wrap, done=1.
